esdi_read_serializer: RTL and testbench

- Bit-serial ESDI read-data source for the drive emulator.
- Sits directly downstream of the sector timer: it takes the current `sector_number` and a byte stream of sector contents from the DMA path.
- While the controller asserts read gate, it drives NRZ read data and read clock: PLL preamble, sync byte, `SECTOR_BYTES` data bytes, then zero fill.

---
 rtl/esdi_read_serializer_pkg.sv | 20 ++
 rtl/esdi_bit_cell_gen.sv | 57 +++++
 rtl/esdi_read_serializer.sv | 198 +++++++++++++++++++
 tb/tb_esdi_read_serializer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esdi_read_serializer_pkg.sv
// Shared framing definitions for the ESDI read serializer and the matching
// write-path deserializer, so both sides agree on preamble, sync and sector size.
package esdi_read_serializer_pkg;

    // Serializer sequencing states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SYNC     = 3'd2,
        ST_DATA     = 3'd3,
        ST_FILL     = 3'd4
    } esdi_rd_state_e;

    localparam int unsigned ESDI_DEF_BIT_DIV        = 4;
    localparam int unsigned ESDI_DEF_PREAMBLE_BYTES = 12;
    localparam logic [7:0]  ESDI_DEF_SYNC_BYTE      = 8'h01;
    localparam int unsigned ESDI_DEF_SECTOR_BYTES   = 512;
    localparam int unsigned ESDI_BYTE_CNT_W         = 16;

endpackage

// File: rtl/esdi_bit_cell_gen.sv
// Bit-cell timing for the ESDI read serializer.
// Ports:
//   clk, rst_n     - system clock, async active-low reset
//   enable_i       - high while the serializer is active in the coming cycle;
//                    low clears the cell counter and read clock to 0
//   read_clock_o   - registered read clock: low for the first half of a cell
//   cell_start_c_o - strobe, first system clock of a cell
//   cell_end_c_o   - strobe, last system clock of a cell
module esdi_bit_cell_gen #(
    parameter int unsigned BIT_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable_i,
    output logic read_clock_o,
    output logic cell_start_c_o,
    output logic cell_end_c_o
);

    localparam int unsigned CNT_W = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
    localparam int unsigned HALF  = BIT_DIV / 2;

    logic [CNT_W-1:0] cell_cnt_q, cell_cnt_d;
    logic             read_clock_q, read_clock_d;
    logic             active_q;

    // The first active cycle starts at count 0; later cycles wrap 0..BIT_DIV-1.
    always_comb begin
        cell_cnt_d   = '0;
        read_clock_d = 1'b0;
        if (enable_i && active_q) begin
            if (cell_cnt_q == CNT_W'(BIT_DIV - 1)) begin
                cell_cnt_d = '0;
            end else begin
                cell_cnt_d = cell_cnt_q + CNT_W'(1);
            end
            read_clock_d = (cell_cnt_d >= CNT_W'(HALF));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cell_cnt_q   <= '0;
            read_clock_q <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            cell_cnt_q   <= cell_cnt_d;
            read_clock_q <= read_clock_d;
            active_q     <= enable_i;
        end
    end

    assign read_clock_o   = read_clock_q;
    assign cell_start_c_o = active_q && (cell_cnt_q == CNT_W'(0));
    assign cell_end_c_o   = active_q && (cell_cnt_q == CNT_W'(BIT_DIV - 1));

endmodule

// File: rtl/esdi_read_serializer.sv
// Bit-serial ESDI read-data source: on a read-gate rise, sends PLL preamble,
// sync byte, SECTOR_BYTES stream bytes, then zero fill, as NRZ data + read clock.
// Optional build macro: ESDI_READ_SER_UNDERRUN_CNT_EN enables the saturating
// underrun_count; without it underrun_count is tied to 0.
// Ports:
//   csr_aclk, csr_aresetn        - system clock, async active-low reset
//   esdi_read_gate               - controller read gate (synchronised)
//   sector_number                - current sector from the sector timer
//   s_axis_tdata/tvalid/tready   - sector byte stream (tready is combinational)
//   esdi_read_data/clock         - NRZ read data and read clock
//   active_sector                - sector latched at read-gate rise
//   busy                         - serializer not idle
//   underrun, underrun_count     - sticky underrun flag, optional counter
module esdi_read_serializer
    import esdi_read_serializer_pkg::*;
#(
    parameter int unsigned BIT_DIV        = ESDI_DEF_BIT_DIV,
    parameter int unsigned PREAMBLE_BYTES = ESDI_DEF_PREAMBLE_BYTES,
    parameter logic [7:0]  SYNC_BYTE      = ESDI_DEF_SYNC_BYTE,
    parameter int unsigned SECTOR_BYTES   = ESDI_DEF_SECTOR_BYTES
) (
    input  logic        csr_aclk,
    input  logic        csr_aresetn,
    input  logic        esdi_read_gate,
    input  logic [7:0]  sector_number,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic        esdi_read_data,
    output logic        esdi_read_clock,
    output logic [7:0]  active_sector,
    output logic        busy,
    output logic        underrun,
    output logic [15:0] underrun_count
);

    localparam int unsigned BC_W = ESDI_BYTE_CNT_W;

    esdi_rd_state_e  state_q, state_d;
    logic            gate_q;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [BC_W-1:0] byte_cnt_q, byte_cnt_d;
    logic            read_data_q, read_data_d;
    logic            underrun_q, underrun_d;
    logic [7:0]      active_sector_q, active_sector_d;
    logic            busy_q;
    logic [7:0]      next_byte_c;
    logic            fetch_c;
    logic            tready_c;
    logic            cell_start_c;
    logic            cell_end_c;
    logic            gate_rise_c;

    assign gate_rise_c = esdi_read_gate && !gate_q;

    esdi_bit_cell_gen #(
        .BIT_DIV (BIT_DIV)
    ) u_cell (
        .clk            (csr_aclk),
        .rst_n          (csr_aresetn),
        .enable_i       (state_d != ST_IDLE),
        .read_clock_o   (esdi_read_clock),
        .cell_start_c_o (cell_start_c),
        .cell_end_c_o   (cell_end_c)
    );

    // Sequencing: the shifter moves on at cell start so that, at cell end,
    // its MSB is already the next bit to present on read data.
    always_comb begin
        state_d         = state_q;
        shift_d         = shift_q;
        bit_idx_d       = bit_idx_q;
        byte_cnt_d      = byte_cnt_q;
        read_data_d     = read_data_q;
        underrun_d      = underrun_q;
        active_sector_d = active_sector_q;
        next_byte_c     = 8'h00;
        fetch_c         = 1'b0;
        tready_c        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                read_data_d = 1'b0;
                if (gate_rise_c) begin
                    active_sector_d = sector_number;
                    underrun_d      = 1'b0;
                    shift_d         = 8'h00;
                    bit_idx_d       = 3'd7;
                    byte_cnt_d      = '0;
                    state_d         = ST_PREAMBLE;
                end
            end
            default: begin
                if (!esdi_read_gate) begin
                    // Abort: partial byte dropped, no fetch this cycle
                    state_d     = ST_IDLE;
                    read_data_d = 1'b0;
                end else begin
                    if (cell_start_c) begin
                        shift_d = {shift_q[6:0], 1'b0};
                    end
                    if (cell_end_c) begin
                        if (bit_idx_q != 3'd0) begin
                            bit_idx_d   = bit_idx_q - 3'd1;
                            read_data_d = shift_q[7];
                        end else begin
                            bit_idx_d = 3'd7;
                            case (state_q)
                                ST_PREAMBLE: begin
                                    if (byte_cnt_q == BC_W'(PREAMBLE_BYTES - 1)) begin
                                        next_byte_c = SYNC_BYTE;
                                        state_d     = ST_SYNC;
                                    end else begin
                                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                                    end
                                end
                                ST_SYNC: begin
                                    fetch_c    = 1'b1;
                                    byte_cnt_d = BC_W'(1);
                                    state_d    = ST_DATA;
                                end
                                ST_DATA: begin
                                    if (byte_cnt_q == BC_W'(SECTOR_BYTES)) begin
                                        state_d = ST_FILL;
                                    end else begin
                                        fetch_c    = 1'b1;
                                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                                    end
                                end
                                default: ;
                            endcase
                            // A missing stream byte becomes 0x00; its slot is not retried
                            if (fetch_c) begin
                                tready_c = 1'b1;
                                if (s_axis_tvalid) begin
                                    next_byte_c = s_axis_tdata;
                                end else begin
                                    underrun_d = 1'b1;
                                end
                            end
                            shift_d     = next_byte_c;
                            read_data_d = next_byte_c[7];
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
        if (!csr_aresetn) begin
            state_q         <= ST_IDLE;
            gate_q          <= 1'b0;
            shift_q         <= 8'h00;
            bit_idx_q       <= 3'd0;
            byte_cnt_q      <= '0;
            read_data_q     <= 1'b0;
            underrun_q      <= 1'b0;
            active_sector_q <= 8'h00;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            gate_q          <= esdi_read_gate;
            shift_q         <= shift_d;
            bit_idx_q       <= bit_idx_d;
            byte_cnt_q      <= byte_cnt_d;
            read_data_q     <= read_data_d;
            underrun_q      <= underrun_d;
            active_sector_q <= active_sector_d;
            busy_q          <= (state_d != ST_IDLE);
        end
    end

`ifdef ESDI_READ_SER_UNDERRUN_CNT_EN
    logic [15:0] underrun_count_q;

    // Saturating count of underrun bytes, cleared only by reset
    always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
        if (!csr_aresetn) begin
            underrun_count_q <= 16'h0000;
        end else if (tready_c && !s_axis_tvalid && (underrun_count_q != 16'hFFFF)) begin
            underrun_count_q <= underrun_count_q + 16'd1;
        end
    end

    assign underrun_count = underrun_count_q;
`else
    assign underrun_count = 16'h0000;
`endif

    assign s_axis_tready  = tready_c;
    assign esdi_read_data = read_data_q;
    assign active_sector  = active_sector_q;
    assign busy           = busy_q;
    assign underrun       = underrun_q;

endmodule

// File: tb/tb_esdi_read_serializer.sv
// Bench for esdi_read_serializer: random sector streams against a byte-level
// framing model (preamble, sync, data with underrun slots, zero fill).
module tb_esdi_read_serializer;

    localparam int unsigned BD       = 4;
    localparam int unsigned PB       = 2;
    localparam int unsigned SB       = 4;
    localparam logic [7:0]  SYNC     = 8'h01;
    localparam int unsigned BYTE_CYC = 8 * BD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        csr_aresetn;
    logic        esdi_read_gate;
    logic [7:0]  sector_number;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        esdi_read_data;
    logic        esdi_read_clock;
    logic [7:0]  active_sector;
    logic        busy;
    logic        underrun;
    logic [15:0] underrun_count;

    logic        gate2;
    logic [7:0]  tdata2;
    logic        tready2, rdata2, rclk2, busy2, under2;
    logic [7:0]  asec2;
    logic [15:0] ucnt2;

    esdi_read_serializer #(
        .BIT_DIV(BD), .PREAMBLE_BYTES(PB), .SYNC_BYTE(SYNC), .SECTOR_BYTES(SB)
    ) u_dut (
        .csr_aclk        (clk),
        .csr_aresetn     (csr_aresetn),
        .esdi_read_gate  (esdi_read_gate),
        .sector_number   (sector_number),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .esdi_read_data  (esdi_read_data),
        .esdi_read_clock (esdi_read_clock),
        .active_sector   (active_sector),
        .busy            (busy),
        .underrun        (underrun),
        .underrun_count  (underrun_count)
    );

    // Second instance with the fastest bit cell, gate held high, for clock shape
    esdi_read_serializer #(
        .BIT_DIV(2), .PREAMBLE_BYTES(PB), .SYNC_BYTE(SYNC), .SECTOR_BYTES(SB)
    ) u_dut2 (
        .csr_aclk        (clk),
        .csr_aresetn     (csr_aresetn),
        .esdi_read_gate  (gate2),
        .sector_number   (8'h55),
        .s_axis_tdata    (tdata2),
        .s_axis_tvalid   (1'b1),
        .s_axis_tready   (tready2),
        .esdi_read_data  (rdata2),
        .esdi_read_clock (rclk2),
        .active_sector   (asec2),
        .busy            (busy2),
        .underrun        (under2),
        .underrun_count  (ucnt2)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic        gate_v = 1'b0;
    int          slot = 0;
    int          bad_slot = -1;
    int          rise_cyc = 0;
    logic [7:0]  src_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  cap_q[$];
    int          tready_cycles[$];
    logic        prev_rclk = 1'b0;
    logic [7:0]  bit_acc = 8'h00;
    int          nbits = 0;
    logic        prev_rclk2 = 1'b0, prev_rdata2 = 1'b0, prev_busy2 = 1'b0;
    int          shape_err = 0, hi2 = 0, lo2 = 0, tready2_cnt = 0;
    int          ucnt_model = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One system clock: drive inputs at the falling edge, sample just after
    task automatic step();
        @(negedge clk);
        esdi_read_gate = gate_v;
        s_axis_tvalid  = (src_q.size() > 0) && (slot != bad_slot);
        s_axis_tdata   = (src_q.size() > 0) ? src_q[0] : 8'h00;
        tdata2         = 8'($urandom_range(0, 255));
        #1;
        cyc++;
        if (s_axis_tready) begin
            tready_cycles.push_back(cyc);
            if (s_axis_tvalid) void'(src_q.pop_front());
            slot++;
        end
        if (esdi_read_clock && !prev_rclk) begin
            bit_acc = {bit_acc[6:0], esdi_read_data};
            nbits++;
            if (nbits % 8 == 0) cap_q.push_back(bit_acc);
        end
        prev_rclk = esdi_read_clock;
        if (busy2 && prev_busy2) begin
            if (rclk2 == prev_rclk2) shape_err++;
            if ((rdata2 != prev_rdata2) && rclk2) shape_err++;
            if (rclk2) hi2++; else lo2++;
        end
        if (tready2) tready2_cnt++;
        prev_rclk2  = rclk2;
        prev_rdata2 = rdata2;
        prev_busy2  = busy2;
    endtask

    task automatic fill_random();
        src_q.delete();
        repeat (SB) src_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Expected serial bytes: preamble zeros, sync, data (lost slot = 0), fill
    task automatic start_sector(input logic [7:0] sec, input int bad);
        int k;
        bad_slot = bad;
        slot     = 0;
        cap_q.delete();
        tready_cycles.delete();
        nbits    = 0;
        bit_acc  = 8'h00;
        exp_q.delete();
        repeat (PB) exp_q.push_back(8'h00);
        exp_q.push_back(SYNC);
        k = 0;
        for (int s = 0; s < int'(SB); s++) begin
            if (s == bad) exp_q.push_back(8'h00);
            else begin
                exp_q.push_back(src_q[k]);
                k++;
            end
        end
        repeat (2) exp_q.push_back(8'h00);
        sector_number = sec;
        gate_v = 1'b1;
        step();
        rise_cyc = cyc;
    endtask

    task automatic check_sector(input logic [7:0] sec, input logic exp_under);
        check_eq("cap_len", 32'(cap_q.size() >= exp_q.size()), 32'd1);
        foreach (exp_q[i]) begin
            if (i < cap_q.size()) check_eq($sformatf("byte%0d", i), 32'(cap_q[i]), 32'(exp_q[i]));
        end
        check_eq("tready_cnt", 32'(tready_cycles.size()), 32'(SB));
        if (tready_cycles.size() > 0)
            check_eq("first_tready", 32'(tready_cycles[0] - rise_cyc), 32'((PB + 1) * BYTE_CYC));
        for (int i = 1; i < tready_cycles.size(); i++)
            check_eq("tready_gap", 32'(tready_cycles[i] - tready_cycles[i-1]), 32'(BYTE_CYC));
        check_eq("underrun", 32'(underrun), 32'(exp_under));
        check_eq("active_sector", 32'(active_sector), 32'(sec));
        check_eq("busy_fill", 32'(busy), 32'd1);
        if (exp_under) ucnt_model++;
`ifdef ESDI_READ_SER_UNDERRUN_CNT_EN
        check_eq("underrun_count", 32'(underrun_count), 32'(ucnt_model));
`else
        check_eq("underrun_count", 32'(underrun_count), 32'd0);
`endif
    endtask

    initial begin
        logic [7:0] sec;
        csr_aresetn    = 1'b0;
        esdi_read_gate = 1'b0;
        sector_number  = 8'h00;
        s_axis_tdata   = 8'h00;
        s_axis_tvalid  = 1'b0;
        gate2          = 1'b0;
        tdata2         = 8'h00;

        // Reset state
        repeat (3) step();
        check_eq("rst_data", 32'(esdi_read_data), 32'd0);
        check_eq("rst_clock", 32'(esdi_read_clock), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_sector", 32'(active_sector), 32'd0);
        check_eq("rst_underrun", 32'(underrun), 32'd0);
        check_eq("rst_ucnt", 32'(underrun_count), 32'd0);
        check_eq("rst_tready", 32'(s_axis_tready), 32'd0);
        csr_aresetn = 1'b1;
        gate2 = 1'b1;
        step();

        // Nominal sector; sector_number changes mid-sector
        src_q.delete();
        src_q.push_back(8'hA5); src_q.push_back(8'h3C);
        src_q.push_back(8'h00); src_q.push_back(8'hFF);
        start_sector(8'd7, -1);
        repeat (120) step();
        sector_number = 8'd8;
        repeat (180) step();
        check_sector(8'd7, 1'b0);

        // Abort from fill
        gate_v = 1'b0;
        step();
        step();
        check_eq("abort_fill_data", 32'(esdi_read_data), 32'd0);
        check_eq("abort_fill_clock", 32'(esdi_read_clock), 32'd0);
        check_eq("abort_fill_busy", 32'(busy), 32'd0);

        // Underrun on the second data load
        fill_random();
        sec = 8'($urandom_range(0, 255));
        start_sector(sec, 1);
        repeat (300) step();
        check_sector(sec, 1'b1);
        check_eq("stream_left", 32'(src_q.size()), 32'd1);
        gate_v = 1'b0;
        step();
        step();

        // Abort on the last cycle of the third data byte
        fill_random();
        sec = 8'($urandom_range(0, 255));
        start_sector(sec, -1);
        for (int k = 0; k < 300 && tready_cycles.size() < 3; k++) step();
        check_eq("wait_3rd", 32'(tready_cycles.size()), 32'd3);
        check_eq("underrun_cleared", 32'(underrun), 32'd0);
        repeat (BYTE_CYC - 1) step();
        gate_v = 1'b0;
        step();
        check_eq("abort_tready", 32'(s_axis_tready), 32'd0);
        step();
        check_eq("abort_data", 32'(esdi_read_data), 32'd0);
        check_eq("abort_clock", 32'(esdi_read_clock), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        repeat (40) step();
        check_eq("abort_no_tready", 32'(tready_cycles.size()), 32'd3);

        // Fresh sequence after abort
        fill_random();
        sec = 8'($urandom_range(0, 255));
        start_sector(sec, -1);
        repeat (300) step();
        check_sector(sec, 1'b0);

        // Gate held on the second instance: exactly one sector of fetches
        check_eq("dut2_tready_cnt", 32'(tready2_cnt), 32'(SB));
        check_eq("dut2_busy", 32'(busy2), 32'd1);

        // Asynchronous reset in the middle of the data phase
        gate_v = 1'b0;
        step();
        step();
        fill_random();
        sec = 8'($urandom_range(0, 255));
        start_sector(sec, -1);
        for (int k = 0; k < 300 && tready_cycles.size() < 2; k++) step();
        check_eq("wait_2nd", 32'(tready_cycles.size()), 32'd2);
        #2;
        csr_aresetn = 1'b0;
        #1;
        check_eq("arst_data", 32'(esdi_read_data), 32'd0);
        check_eq("arst_clock", 32'(esdi_read_clock), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_sector", 32'(active_sector), 32'd0);
        check_eq("arst_ucnt", 32'(underrun_count), 32'd0);
        check_eq("arst_tready", 32'(s_axis_tready), 32'd0);
        ucnt_model = 0;
        gate_v = 1'b0;
        step();
        step();
        csr_aresetn = 1'b1;
        repeat (40) step();

        // Clock shape at two system clocks per cell
        check_eq("shape_err", 32'(shape_err), 32'd0);
        check_eq("shape_seen", 32'(hi2 > 100), 32'd1);
        check_eq("shape_duty", 32'((hi2 - lo2 <= 1) && (lo2 - hi2 <= 1)), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
